// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register bank: register indices, FSM states and IRQ bits.
package spi_reg_pkg;

    localparam int IDX_W = 7;
    localparam int IRQ_W = 3;

    localparam logic [IDX_W-1:0] REG_ID       = 7'h00;
    localparam logic [IDX_W-1:0] REG_STATUS   = 7'h01;
    localparam logic [IDX_W-1:0] REG_CTRL     = 7'h02;
    localparam logic [IDX_W-1:0] REG_SCRATCH  = 7'h03;
    localparam logic [IDX_W-1:0] REG_WR_CNT   = 7'h04;
    localparam logic [IDX_W-1:0] REG_IRQ_STAT = 7'h05;
    localparam logic [IDX_W-1:0] REG_IRQ_EN   = 7'h06;
    localparam logic [IDX_W-1:0] REG_ERR_CNT  = 7'h07;

    localparam int IRQ_CTRL_BIT    = 0;
    localparam int IRQ_SCRATCH_BIT = 1;
    localparam int IRQ_EVT_BIT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank behind spi_slave: one commit per i_spi_over period, registered read mux, IRQ.
// Optional feature: define SPI_REG_ERRCNT_EN to add the ERR_CNT register at index 0x07.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 16'h0AD0,
    parameter logic [DATA_WIDTH-1:0] CTRL_RST   = 16'h0000
) (
    input  logic                  clk_out1,
    input  logic                  i_rst_n,
    input  logic                  i_spi_over,
    input  logic                  i_txreq,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_rxdata,
    input  logic [DATA_WIDTH-1:0] i_status,
    input  logic                  i_evt,
    output logic [DATA_WIDTH-1:0] o_txdata,
    output logic [DATA_WIDTH-1:0] o_ctrl,
    output logic                  o_wr_pulse,
    output logic [IDX_W-1:0]      o_wr_index,
    output logic                  o_irq
);

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        index;
    logic                    unused_rw_flag;
    logic                    commit;
    logic                    is_rw;
    logic                    wr_pulse;
    logic [DATA_WIDTH-1:0]   scratch;
    logic [DATA_WIDTH-1:0]   wr_cnt;
    logic [IRQ_W-1:0]        irq_stat;
    logic [IRQ_W-1:0]        irq_en;
    logic [IRQ_W-1:0]        irq_set;
    logic [IRQ_W-1:0]        irq_clr;
    logic [DATA_WIDTH-1:0]   rd_word;

    // The rw flag only tells spi_slave the direction; decode uses the index alone.
    assign index          = i_addr[IDX_W-1:0];
    assign unused_rw_flag = i_addr[ADDR_WIDTH-1];
    assign commit         = (state == ST_COMMIT);
    assign is_rw          = (index == REG_CTRL) || (index == REG_SCRATCH) ||
                            (index == REG_IRQ_STAT) || (index == REG_IRQ_EN);

    // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
    always_ff @(posedge clk_out1 or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        wr_pulse = 1'b0;
        case (state)
            ST_IDLE:   if (i_spi_over) state_nx = i_txreq ? ST_HOLD : ST_COMMIT;
            ST_COMMIT: begin
                state_nx = ST_HOLD;
                wr_pulse = is_rw;
            end
            ST_HOLD:   if (!i_spi_over) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    assign o_wr_pulse = wr_pulse;

    always_comb begin
        irq_set                  = '0;
        irq_set[IRQ_CTRL_BIT]    = wr_pulse && (index == REG_CTRL);
        irq_set[IRQ_SCRATCH_BIT] = wr_pulse && (index == REG_SCRATCH);
        irq_set[IRQ_EVT_BIT]     = i_evt;
        irq_clr                  = (wr_pulse && (index == REG_IRQ_STAT)) ? i_rxdata[IRQ_W-1:0] : '0;
    end

    always_ff @(posedge clk_out1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ctrl     <= CTRL_RST;
            scratch    <= '0;
            wr_cnt     <= '0;
            irq_stat   <= '0;
            irq_en     <= '0;
            o_wr_index <= '0;
            o_irq      <= 1'b0;
        end else begin
            if (wr_pulse) begin
                wr_cnt     <= wr_cnt + 1'b1;
                o_wr_index <= index;
                if (index == REG_CTRL)    o_ctrl  <= i_rxdata;
                if (index == REG_SCRATCH) scratch <= i_rxdata;
                if (index == REG_IRQ_EN)  irq_en  <= i_rxdata[IRQ_W-1:0];
            end
            // Set has priority over a W1C clear landing in the same cycle.
            irq_stat <= (irq_stat & ~irq_clr) | irq_set;
            o_irq    <= |(irq_stat & irq_en);
        end
    end

`ifdef SPI_REG_ERRCNT_EN
    logic [DATA_WIDTH-1:0] err_cnt;

    always_ff @(posedge clk_out1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (commit && (index == REG_WR_CNT)) begin
            err_cnt <= '0;
        end else if (commit && !is_rw && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        rd_word = '0;
        case (index)
            REG_ID:       rd_word = ID_VALUE;
            REG_STATUS:   rd_word = i_status;
            REG_CTRL:     rd_word = o_ctrl;
            REG_SCRATCH:  rd_word = scratch;
            REG_WR_CNT:   rd_word = wr_cnt;
            REG_IRQ_STAT: rd_word = {{(DATA_WIDTH-IRQ_W){1'b0}}, irq_stat};
            REG_IRQ_EN:   rd_word = {{(DATA_WIDTH-IRQ_W){1'b0}}, irq_en};
`ifdef SPI_REG_ERRCNT_EN
            REG_ERR_CNT:  rd_word = err_cnt;
`endif
            default:      rd_word = '0;
        endcase
    end

    // The read word is frozen during COMMIT so spi_slave never sees a half-updated value.
    always_ff @(posedge clk_out1 or negedge i_rst_n) begin
        if (!i_rst_n)     o_txdata <= '0;
        else if (!commit) o_txdata <= rd_word;
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: a directed vector table plus hand-written corner sequences.
module tb_spi_reg_bank;

    logic        clk_out1;
    logic        i_rst_n;
    logic        i_spi_over;
    logic        i_txreq;
    logic [7:0]  i_addr;
    logic [15:0] i_rxdata;
    logic [15:0] i_status;
    logic        i_evt;
    logic [15:0] o_txdata;
    logic [15:0] o_ctrl;
    logic        o_wr_pulse;
    logic [6:0]  o_wr_index;
    logic        o_irq;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SPI_REG_ERRCNT_EN
    localparam logic [15:0] ERR_ONE = 16'h0001;
`else
    localparam logic [15:0] ERR_ONE = 16'h0000;
`endif

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] status;
        int          len;
        int          exp_pulses;
        logic [15:0] exp_rd;
        logic [6:0]  exp_idx;
        logic [15:0] exp_ctrl;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    spi_reg_bank dut (
        .clk_out1   (clk_out1),
        .i_rst_n    (i_rst_n),
        .i_spi_over (i_spi_over),
        .i_txreq    (i_txreq),
        .i_addr     (i_addr),
        .i_rxdata   (i_rxdata),
        .i_status   (i_status),
        .i_evt      (i_evt),
        .o_txdata   (o_txdata),
        .o_ctrl     (o_ctrl),
        .o_wr_pulse (o_wr_pulse),
        .o_wr_index (o_wr_index),
        .o_irq      (o_irq)
    );

    initial clk_out1 = 1'b0;
    always #5 clk_out1 = ~clk_out1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic [7:0] addr, input logic [15:0] data,
                       input logic [15:0] status, input int len, input int exp_pulses,
                       input logic [15:0] exp_rd, input logic [6:0] exp_idx,
                       input logic [15:0] exp_ctrl, input logic exp_irq);
        vec_t v;
        v.rd = rd;  v.addr = addr;  v.data = data;  v.status = status;  v.len = len;
        v.exp_pulses = exp_pulses;  v.exp_rd = exp_rd;  v.exp_idx = exp_idx;
        v.exp_ctrl = exp_ctrl;  v.exp_irq = exp_irq;
        vecs.push_back(v);
    endtask

    // Entered and left at #1 after a rising edge; counts write strobes over the whole transaction.
    task automatic spi_txn(input logic rd, input logic [7:0] addr, input logic [15:0] data,
                           input int len, output int pulses);
        pulses     = 0;
        i_txreq    = rd;
        i_addr     = addr;
        i_rxdata   = data;
        i_spi_over = 1'b1;
        for (int c = 0; c < len + 3; c++) begin
            @(negedge clk_out1);
            if (o_wr_pulse) pulses++;
            @(posedge clk_out1); #1;
            if (c == len - 1) i_spi_over = 1'b0;
        end
    endtask

    task automatic rd_check(input string name, input logic [7:0] addr, input logic [15:0] exp);
        i_txreq = 1'b1;
        i_addr  = addr;
        @(posedge clk_out1); #1;
        check(name, o_txdata, exp);
    endtask

    int pulses;

    initial begin
        i_rst_n    = 1'b0;
        i_spi_over = 1'b0;
        i_txreq    = 1'b0;
        i_addr     = 8'h00;
        i_rxdata   = 16'h0000;
        i_status   = 16'h0000;
        i_evt      = 1'b0;

        //   rd    addr   data      status    len pul exp_rd    idx    ctrl      irq
        add(1'b0, 8'h02, 16'h1234, 16'h0000, 5, 1, 16'h0000, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h02, 16'h0000, 16'h0000, 2, 0, 16'h1234, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h04, 16'h0000, 16'h0000, 2, 0, 16'h0001, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h05, 16'h0000, 16'h0000, 2, 0, 16'h0001, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h00, 16'h0000, 16'h0000, 2, 0, 16'h0AD0, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h01, 16'h0000, 16'hBEEF, 2, 0, 16'hBEEF, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h7F, 16'h0000, 16'h0000, 2, 0, 16'h0000, 7'h02, 16'h1234, 1'b0);
        add(1'b0, 8'h00, 16'hFFFF, 16'h0000, 2, 0, 16'h0000, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h00, 16'h0000, 16'h0000, 2, 0, 16'h0AD0, 7'h02, 16'h1234, 1'b0);
        add(1'b1, 8'h04, 16'h0000, 16'h0000, 2, 0, 16'h0001, 7'h02, 16'h1234, 1'b0);
        add(1'b0, 8'h83, 16'hA5A5, 16'h0000, 1, 1, 16'h0000, 7'h03, 16'h1234, 1'b0);
        add(1'b1, 8'h03, 16'h0000, 16'h0000, 2, 0, 16'hA5A5, 7'h03, 16'h1234, 1'b0);
        add(1'b1, 8'h04, 16'h0000, 16'h0000, 2, 0, 16'h0002, 7'h03, 16'h1234, 1'b0);
        add(1'b1, 8'h05, 16'h0000, 16'h0000, 2, 0, 16'h0003, 7'h03, 16'h1234, 1'b0);
        add(1'b0, 8'h05, 16'h0001, 16'h0000, 3, 1, 16'h0000, 7'h05, 16'h1234, 1'b0);
        add(1'b1, 8'h05, 16'h0000, 16'h0000, 2, 0, 16'h0002, 7'h05, 16'h1234, 1'b0);
        add(1'b1, 8'h07, 16'h0000, 16'h0000, 2, 0, ERR_ONE,  7'h05, 16'h1234, 1'b0);
        add(1'b0, 8'h06, 16'hFFFF, 16'h0000, 2, 1, 16'h0000, 7'h06, 16'h1234, 1'b1);
        add(1'b1, 8'h06, 16'h0000, 16'h0000, 2, 0, 16'h0007, 7'h06, 16'h1234, 1'b1);
        add(1'b0, 8'h04, 16'h1111, 16'h0000, 2, 0, 16'h0000, 7'h06, 16'h1234, 1'b1);
        add(1'b1, 8'h07, 16'h0000, 16'h0000, 2, 0, 16'h0000, 7'h06, 16'h1234, 1'b1);
        add(1'b1, 8'h04, 16'h0000, 16'h0000, 2, 0, 16'h0004, 7'h06, 16'h1234, 1'b1);
        add(1'b1, 8'h85, 16'h0000, 16'h0000, 2, 0, 16'h0002, 7'h06, 16'h1234, 1'b1);
        add(1'b0, 8'h7F, 16'h1234, 16'h0000, 2, 0, 16'h0000, 7'h06, 16'h1234, 1'b1);
        add(1'b1, 8'h07, 16'h0000, 16'h0000, 2, 0, ERR_ONE,  7'h06, 16'h1234, 1'b1);
        add(1'b1, 8'h04, 16'h0000, 16'h0000, 2, 0, 16'h0004, 7'h06, 16'h1234, 1'b1);

        repeat (3) @(posedge clk_out1);
        #1;
        check("reset o_txdata",   o_txdata,            16'h0000);
        check("reset o_ctrl",     o_ctrl,              16'h0000);
        check("reset o_wr_pulse", 16'(o_wr_pulse),     16'h0000);
        check("reset o_wr_index", 16'(o_wr_index),     16'h0000);
        check("reset o_irq",      16'(o_irq),          16'h0000);
        i_rst_n = 1'b1;
        @(posedge clk_out1); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            i_status = vecs[i].status;
            if (vecs[i].rd)
                rd_check($sformatf("v%0d read 0x%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp_rd);
            spi_txn(vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].len, pulses);
            check($sformatf("v%0d pulses", i),     16'(pulses),            16'(vecs[i].exp_pulses));
            check($sformatf("v%0d o_wr_index", i), 16'(o_wr_index),        16'(vecs[i].exp_idx));
            check($sformatf("v%0d o_ctrl", i),     o_ctrl,                 vecs[i].exp_ctrl);
            check($sformatf("v%0d o_irq", i),      16'(o_irq),             16'(vecs[i].exp_irq));
        end

        // IRQ_STAT: clear bit1, then an event colliding with a W1C of bit2 must keep bit2 set.
        spi_txn(1'b0, 8'h05, 16'h0002, 2, pulses);
        check("w1c bit1 o_irq", 16'(o_irq), 16'h0000);
        rd_check("w1c bit1 stat", 8'h05, 16'h0000);
        i_evt = 1'b1;
        @(posedge clk_out1); #1;
        i_evt = 1'b0;
        rd_check("evt stat", 8'h05, 16'h0004);
        check("evt o_irq", 16'(o_irq), 16'h0001);

        i_txreq    = 1'b0;
        i_addr     = 8'h05;
        i_rxdata   = 16'h0004;
        i_spi_over = 1'b1;
        @(posedge clk_out1); #1;
        check("collide pulse", 16'(o_wr_pulse), 16'h0001);
        i_evt = 1'b1;
        @(posedge clk_out1); #1;
        i_evt      = 1'b0;
        i_spi_over = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("collide o_irq c%0d", c), 16'(o_irq), 16'h0001);
            @(posedge clk_out1); #1;
        end
        rd_check("collide stat", 8'h05, 16'h0004);

        spi_txn(1'b0, 8'h05, 16'h0004, 2, pulses);
        check("w1c bit2 o_irq", 16'(o_irq), 16'h0000);
        rd_check("w1c bit2 stat", 8'h05, 16'h0000);
        rd_check("wr_cnt before wrap", 8'h04, 16'h0007);

        // WR_CNT wrap from 16'hFFFF.
        i_txreq = 1'b1;
        i_addr  = 8'h04;
        force dut.wr_cnt = 16'hFFFF;
        @(posedge clk_out1); #1;
        release dut.wr_cnt;
        rd_check("wr_cnt preload", 8'h04, 16'hFFFF);
        spi_txn(1'b0, 8'h03, 16'h0F0F, 1, pulses);
        check("wrap pulses", 16'(pulses), 16'h0001);
        rd_check("wr_cnt wrapped", 8'h04, 16'h0000);
        rd_check("scratch after wrap", 8'h03, 16'h0F0F);

        // Reset while in HOLD; i_spi_over still high at release is a fresh write.
        i_txreq    = 1'b1;
        i_addr     = 8'h03;
        i_spi_over = 1'b1;
        repeat (2) @(posedge clk_out1);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("hold rst o_txdata",   o_txdata,          16'h0000);
        check("hold rst o_ctrl",     o_ctrl,            16'h0000);
        check("hold rst o_wr_index", 16'(o_wr_index),   16'h0000);
        check("hold rst o_irq",      16'(o_irq),        16'h0000);
        i_txreq  = 1'b0;
        i_addr   = 8'h02;
        i_rxdata = 16'h5555;
        @(posedge clk_out1); #1;
        check("hold rst o_wr_pulse", 16'(o_wr_pulse), 16'h0000);
        i_rst_n = 1'b1;
        pulses  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_out1);
            if (o_wr_pulse) pulses++;
            @(posedge clk_out1); #1;
            if (c == 0) i_spi_over = 1'b0;
        end
        check("post rst pulses",     16'(pulses),     16'h0001);
        check("post rst o_ctrl",     o_ctrl,          16'h5555);
        check("post rst o_wr_index", 16'(o_wr_index), 16'h0002);
        rd_check("post rst wr_cnt", 8'h04, 16'h0001);
        rd_check("post rst stat",   8'h05, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
